// File: rtl/issue_queue_if.sv
// Dispatch, wakeup and FU request/response bundle for issue_queue.
// The queue takes the slave side; the dispatch stage and FU take the master side.
interface issue_queue_if #(
  parameter int unsigned ENTRIES = 8
);
  localparam int unsigned CW = $clog2(ENTRIES + 1);

  logic          flush;
  logic          dispatch_valid;
  logic [3:0]    dispatch_ALUControl;
  logic          dispatch_ALUSrc;
  logic          dispatch_is_for_lsq;
  logic [31:0]   dispatch_imm;
  logic          dispatch_rs1_ready;
  logic          dispatch_rs2_ready;
  logic [5:0]    dispatch_rs1_tag;
  logic [5:0]    dispatch_rs2_tag;
  logic [31:0]   dispatch_rs1_value;
  logic [31:0]   dispatch_rs2_value;
  logic [5:0]    dispatch_tag_to_output;
  logic [5:0]    dispatch_rob_index;
  logic          wakeup_active;
  logic [5:0]    wakeup_tag;
  logic [31:0]   wakeup_value;
  logic          fu_is_available;
  logic          fu_write_enable;
  logic [3:0]    fu_ALUControl;
  logic          fu_ALUSrc;
  logic          fu_is_for_lsq;
  logic [31:0]   fu_imm;
  logic [31:0]   fu_rs1_value;
  logic [31:0]   fu_rs2_value;
  logic [5:0]    fu_tag_to_output;
  logic [5:0]    fu_rob_index;
  logic          queue_full;
  logic [CW-1:0] count;

  modport slave (
    input  flush, dispatch_valid, dispatch_ALUControl, dispatch_ALUSrc,
           dispatch_is_for_lsq, dispatch_imm, dispatch_rs1_ready, dispatch_rs2_ready,
           dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rs1_value, dispatch_rs2_value,
           dispatch_tag_to_output, dispatch_rob_index,
           wakeup_active, wakeup_tag, wakeup_value, fu_is_available,
    output fu_write_enable, fu_ALUControl, fu_ALUSrc, fu_is_for_lsq, fu_imm,
           fu_rs1_value, fu_rs2_value, fu_tag_to_output, fu_rob_index,
           queue_full, count
  );

  modport master (
    output flush, dispatch_valid, dispatch_ALUControl, dispatch_ALUSrc,
           dispatch_is_for_lsq, dispatch_imm, dispatch_rs1_ready, dispatch_rs2_ready,
           dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rs1_value, dispatch_rs2_value,
           dispatch_tag_to_output, dispatch_rob_index,
           wakeup_active, wakeup_tag, wakeup_value, fu_is_available,
    input  fu_write_enable, fu_ALUControl, fu_ALUSrc, fu_is_for_lsq, fu_imm,
           fu_rs1_value, fu_rs2_value, fu_tag_to_output, fu_rob_index,
           queue_full, count
  );
endinterface

// File: rtl/issue_queue.sv
// Age-ordered reservation station for one FU: snoops register wakeups,
// issues the oldest ready entry and compacts younger entries down.
module issue_queue #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic          clk,
  input  logic          reset,
  issue_queue_if.slave  iq
);
  localparam int unsigned CW = $clog2(ENTRIES + 1);
  localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic        src;
    logic        lsq;
    logic [31:0] imm;
    logic [5:0]  tout;
    logic [5:0]  rob;
    logic        rdy1;
    logic [5:0]  tag1;
    logic [31:0] val1;
    logic        rdy2;
    logic [5:0]  tag2;
    logic [31:0] val2;
  } entry_t;

  entry_t        ent_q [ENTRIES];
  entry_t        ent_d [ENTRIES];
  entry_t        woken [ENTRIES+1];
  entry_t        new_e;
  logic [CW-1:0] count_q, count_d, wr_pos;
  logic [IW-1:0] sel_idx;
  logic          found, issue, wake, accept, full, wait1, wait2;

  assign full   = (count_q == CW'(ENTRIES));
  assign wake   = iq.wakeup_active && (iq.wakeup_tag != '0);
  assign accept = iq.dispatch_valid && !full && !iq.flush;
  assign issue  = iq.fu_is_available && found;
  assign wr_pos = count_q - {{(CW-1){1'b0}}, issue};

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!found && ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        found   = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  // rs2 is inherently ready for immediate-form ops, so it never snoops a wakeup
  always_comb begin
    wait1 = !iq.dispatch_rs1_ready;
    wait2 = !iq.dispatch_ALUSrc && !iq.dispatch_rs2_ready;
    new_e       = '0;
    new_e.valid = 1'b1;
    new_e.alu   = iq.dispatch_ALUControl;
    new_e.src   = iq.dispatch_ALUSrc;
    new_e.lsq   = iq.dispatch_is_for_lsq;
    new_e.imm   = iq.dispatch_imm;
    new_e.tout  = iq.dispatch_tag_to_output;
    new_e.rob   = iq.dispatch_rob_index;
    new_e.tag1  = iq.dispatch_rs1_tag;
    new_e.tag2  = iq.dispatch_rs2_tag;
    new_e.rdy1  = !wait1;
    new_e.val1  = iq.dispatch_rs1_value;
    new_e.rdy2  = !wait2;
    new_e.val2  = iq.dispatch_rs2_value;
    if (wait1 && wake && iq.dispatch_rs1_tag == iq.wakeup_tag) begin
      new_e.rdy1 = 1'b1;
      new_e.val1 = iq.wakeup_value;
    end
    if (wait2 && wake && iq.dispatch_rs2_tag == iq.wakeup_tag) begin
      new_e.rdy2 = 1'b1;
      new_e.val2 = iq.wakeup_value;
    end
  end

  // Wakeup first, then drop the issued slot by shifting, then append at the tail
  always_comb begin
    woken[ENTRIES] = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      woken[i] = ent_q[i];
      if (wake && ent_q[i].valid && !ent_q[i].rdy1 && ent_q[i].tag1 == iq.wakeup_tag) begin
        woken[i].rdy1 = 1'b1;
        woken[i].val1 = iq.wakeup_value;
      end
      if (wake && ent_q[i].valid && !ent_q[i].rdy2 && ent_q[i].tag2 == iq.wakeup_tag) begin
        woken[i].rdy2 = 1'b1;
        woken[i].val2 = iq.wakeup_value;
      end
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      ent_d[i] = (issue && i >= 32'(sel_idx)) ? woken[i+1] : woken[i];
      if (accept && i == 32'(wr_pos)) ent_d[i] = new_e;
    end
    count_d = count_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, issue};
  end

  always_ff @(posedge clk) begin
    if (reset || iq.flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

  assign iq.fu_write_enable  = issue;
  assign iq.fu_ALUControl    = issue ? ent_q[sel_idx].alu  : '0;
  assign iq.fu_ALUSrc        = issue ? ent_q[sel_idx].src  : '0;
  assign iq.fu_is_for_lsq    = issue ? ent_q[sel_idx].lsq  : '0;
  assign iq.fu_imm           = issue ? ent_q[sel_idx].imm  : '0;
  assign iq.fu_rs1_value     = issue ? ent_q[sel_idx].val1 : '0;
  assign iq.fu_rs2_value     = issue ? ent_q[sel_idx].val2 : '0;
  assign iq.fu_tag_to_output = issue ? ent_q[sel_idx].tout : '0;
  assign iq.fu_rob_index     = issue ? ent_q[sel_idx].rob  : '0;
  assign iq.queue_full       = full;
  assign iq.count            = count_q;
endmodule

// File: tb/tb_issue_queue.sv
// Randomised bench for issue_queue against a queue-based reference model,
// preceded by directed scenarios with hand-computed expectations.
module tb_issue_queue;
  localparam int unsigned ENTRIES = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  issue_queue_if #(.ENTRIES(ENTRIES)) iq_if ();
  issue_queue #(.ENTRIES(ENTRIES)) dut (.clk(clk), .reset(reset), .iq(iq_if));

  typedef struct {
    logic [3:0]  alu;
    logic        src, lsq;
    logic [31:0] imm;
    logic [5:0]  tout, rob;
    logic        r1;
    logic [5:0]  t1;
    logic [31:0] v1;
    logic        r2;
    logic [5:0]  t2;
    logic [31:0] v2;
  } m_t;

  m_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  // Reference model: plain list of entries in age order
  always @(posedge clk) begin
    if (reset || iq_if.flush) begin
      mq.delete();
    end else begin
      int  sel;
      bit  acc, wk;
      m_t  n;
      sel = oldest_ready();
      acc = iq_if.dispatch_valid && (mq.size() < ENTRIES);
      wk  = iq_if.wakeup_active && iq_if.wakeup_tag != 0;
      foreach (mq[i]) begin
        if (wk && !mq[i].r1 && mq[i].t1 == iq_if.wakeup_tag) begin mq[i].r1 = 1; mq[i].v1 = iq_if.wakeup_value; end
        if (wk && !mq[i].r2 && mq[i].t2 == iq_if.wakeup_tag) begin mq[i].r2 = 1; mq[i].v2 = iq_if.wakeup_value; end
      end
      if (iq_if.fu_is_available && sel >= 0) mq.delete(sel);
      if (acc) begin
        n.alu = iq_if.dispatch_ALUControl; n.src = iq_if.dispatch_ALUSrc;
        n.lsq = iq_if.dispatch_is_for_lsq; n.imm = iq_if.dispatch_imm;
        n.tout = iq_if.dispatch_tag_to_output; n.rob = iq_if.dispatch_rob_index;
        n.t1 = iq_if.dispatch_rs1_tag; n.t2 = iq_if.dispatch_rs2_tag;
        n.r1 = iq_if.dispatch_rs1_ready; n.v1 = iq_if.dispatch_rs1_value;
        n.r2 = iq_if.dispatch_ALUSrc || iq_if.dispatch_rs2_ready; n.v2 = iq_if.dispatch_rs2_value;
        if (!n.r1 && wk && n.t1 == iq_if.wakeup_tag) begin n.r1 = 1; n.v1 = iq_if.wakeup_value; end
        if (!n.r2 && wk && n.t2 == iq_if.wakeup_tag) begin n.r2 = 1; n.v2 = iq_if.wakeup_value; end
        mq.push_back(n);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      int sel;
      m_t e;
      bit we;
      sel = oldest_ready();
      we  = iq_if.fu_is_available && sel >= 0;
      e   = '{default: '0};
      if (we) e = mq[sel];
      chk("m_we",    32'(iq_if.fu_write_enable), 32'(we));
      chk("m_alu",   32'(iq_if.fu_ALUControl), 32'(e.alu));
      chk("m_src",   32'(iq_if.fu_ALUSrc), 32'(e.src));
      chk("m_lsq",   32'(iq_if.fu_is_for_lsq), 32'(e.lsq));
      chk("m_imm",   iq_if.fu_imm, e.imm);
      chk("m_rs1",   iq_if.fu_rs1_value, e.v1);
      chk("m_rs2",   iq_if.fu_rs2_value, e.v2);
      chk("m_tout",  32'(iq_if.fu_tag_to_output), 32'(e.tout));
      chk("m_rob",   32'(iq_if.fu_rob_index), 32'(e.rob));
      chk("m_count", 32'(iq_if.count), 32'(mq.size()));
      chk("m_full",  32'(iq_if.queue_full), 32'(mq.size() == ENTRIES));
    end
  end

  task automatic idle();
    iq_if.dispatch_valid = 0;
    iq_if.wakeup_active  = 0;
    iq_if.wakeup_tag     = 0;
    iq_if.wakeup_value   = 0;
    iq_if.flush          = 0;
  endtask

  task automatic disp(input logic [3:0] alu, input logic src, input logic [31:0] imm,
                      input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] v2,
                      input logic [5:0] tout, input logic [5:0] rob);
    iq_if.dispatch_valid = 1;
    iq_if.dispatch_ALUControl = alu; iq_if.dispatch_ALUSrc = src;
    iq_if.dispatch_is_for_lsq = 0;   iq_if.dispatch_imm = imm;
    iq_if.dispatch_rs1_ready = r1;   iq_if.dispatch_rs1_tag = t1; iq_if.dispatch_rs1_value = v1;
    iq_if.dispatch_rs2_ready = r2;   iq_if.dispatch_rs2_tag = t2; iq_if.dispatch_rs2_value = v2;
    iq_if.dispatch_tag_to_output = tout; iq_if.dispatch_rob_index = rob;
  endtask

  task automatic wake(input logic [5:0] tag, input logic [31:0] val);
    iq_if.wakeup_active = 1; iq_if.wakeup_tag = tag; iq_if.wakeup_value = val;
  endtask

  // Each step: advance to the falling edge, drive idle defaults; checks follow at +3
  task automatic step();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    iq_if.dispatch_valid = 0;
    iq_if.fu_is_available = 1;
    reset = 1;
    step(); step();
    reset = 0; chk_en = 1;
    #3 chk("rst_count", 32'(iq_if.count), 0);
    chk("rst_we", 32'(iq_if.fu_write_enable), 0);
    chk("rst_full", 32'(iq_if.queue_full), 0);

    // ADD with both operands ready
    step(); disp(4'b0010, 0, 0, 1, 0, 2, 1, 0, 3, 4, 3);
    step(); #3;
    chk("add_we", 32'(iq_if.fu_write_enable), 1);
    chk("add_rs1", iq_if.fu_rs1_value, 2);
    chk("add_rs2", iq_if.fu_rs2_value, 3);
    chk("add_tag", 32'(iq_if.fu_tag_to_output), 4);
    chk("add_rob", 32'(iq_if.fu_rob_index), 3);
    step(); #3;
    chk("add_cnt", 32'(iq_if.count), 0);
    chk("add_we0", 32'(iq_if.fu_write_enable), 0);

    // SRA waiting on tag 7; tag-0 broadcast must not wake it
    step(); disp(4'b1011, 1, 1, 0, 7, 0, 0, 0, 0, 10, 5);
    step(); wake(0, 32'h55); #3 chk("sra_wait", 32'(iq_if.fu_write_enable), 0);
    step(); wake(7, 32'hFFFFFFFB); #3 chk("sra_tag0", 32'(iq_if.fu_write_enable), 0);
    step(); #3;
    chk("sra_we", 32'(iq_if.fu_write_enable), 1);
    chk("sra_rs1", iq_if.fu_rs1_value, 32'hFFFFFFFB);
    chk("sra_src", 32'(iq_if.fu_ALUSrc), 1);
    chk("sra_imm", iq_if.fu_imm, 1);

    // Ordering and hold: A waits on tag 9, B and C ready
    step(); iq_if.fu_is_available = 0; disp(1, 0, 0, 0, 9, 0, 1, 0, 0, 11, 1);
    step(); disp(2, 0, 0, 1, 0, 20, 1, 0, 0, 12, 2);
    step(); disp(3, 0, 0, 1, 0, 30, 1, 0, 0, 13, 3);
    step(); #3;
    chk("hold_cnt", 32'(iq_if.count), 3);
    chk("hold_we", 32'(iq_if.fu_write_enable), 0);
    step(); iq_if.fu_is_available = 1; #3 chk("ord_b", 32'(iq_if.fu_rob_index), 2);
    step(); #3 chk("ord_c", 32'(iq_if.fu_rob_index), 3);
    step(); wake(9, 32'h99); #3 chk("ord_none", 32'(iq_if.fu_write_enable), 0);
    step(); #3;
    chk("ord_a", 32'(iq_if.fu_rob_index), 1);
    chk("ord_a_rs1", iq_if.fu_rs1_value, 32'h99);

    // Fill to ENTRIES waiting on tag 12, then a dropped ninth dispatch
    for (int k = 0; k < ENTRIES; k++) begin
      step(); disp(4, 0, 0, 0, 12, 0, 1, 0, 0, 14, 6'(k));
    end
    step(); disp(5, 0, 0, 1, 0, 0, 1, 0, 0, 15, 20); #3;
    chk("full_flag", 32'(iq_if.queue_full), 1);
    chk("full_cnt", 32'(iq_if.count), 8);
    step(); wake(12, 32'hC); #3 chk("drop_cnt", 32'(iq_if.count), 8);
    step(); #3;
    chk("full_issue", 32'(iq_if.fu_rob_index), 0);
    chk("full_still", 32'(iq_if.queue_full), 1);
    step(); #3;
    chk("full_drop", 32'(iq_if.queue_full), 0);
    chk("full_cnt7", 32'(iq_if.count), 7);
    repeat (7) step();
    #3 chk("drain_cnt", 32'(iq_if.count), 0);

    // Dispatch-time snoop on rs2
    step(); disp(6, 0, 0, 1, 0, 1, 0, 5, 0, 16, 7); wake(5, 42);
    step(); #3;
    chk("snoop_we", 32'(iq_if.fu_write_enable), 1);
    chk("snoop_rs2", iq_if.fu_rs2_value, 42);

    // Flush with four entries and a concurrent dispatch
    step(); iq_if.fu_is_available = 0;
    for (int k = 0; k < 4; k++) begin
      disp(7, 0, 0, 1, 0, 0, 1, 0, 0, 17, 6'(k));
      step();
    end
    disp(7, 0, 0, 1, 0, 0, 1, 0, 0, 17, 9); iq_if.flush = 1;
    step(); iq_if.fu_is_available = 1; #3;
    chk("flush_cnt", 32'(iq_if.count), 0);
    chk("flush_we", 32'(iq_if.fu_write_enable), 0);

    // Random traffic with a small tag space so wakeups hit often
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      iq_if.flush = ($urandom_range(0, 149) == 0);
      iq_if.fu_is_available = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6)
        disp(4'($urandom), 1'($urandom), $urandom, 1'($urandom), 6'($urandom_range(0, 7)), $urandom,
             1'($urandom), 6'($urandom_range(0, 7)), $urandom, 6'($urandom), 6'($urandom));
      if ($urandom_range(0, 9) < 4) wake(6'($urandom_range(0, 7)), $urandom);
      iq_if.dispatch_is_for_lsq = 1'($urandom);
    end
    step(); reset = 0;
    step(); #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
# issue_queue

Reservation station feeding one FunctionalUnit in the out-of-order core. It holds dispatched instructions until their source operands are ready, captures operand values from the FU wakeup broadcast, and issues the oldest ready entry to the FU on its write_enable/is_available handshake. It drives the FU's request side and consumes the FU's result side.

## Interface

- ENTRIES, 8: queue depth. Range 2–32.
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of all entries; a dispatch in the same cycle is dropped.
- dispatch_valid  in  1  dispatch request this cycle.
- dispatch_ALUControl  in  4  FU operation.
- dispatch_ALUSrc  in  1  0: rs1 op rs2; 1: rs1 op imm.
- dispatch_is_for_lsq  in  1  result goes to the LSQ wakeup port.
- dispatch_imm  in  32  immediate.
- dispatch_rs1_ready / dispatch_rs2_ready  in  1 each  operand value is valid at dispatch.
- dispatch_rs1_tag / dispatch_rs2_tag  in  6 each  producer tag when not ready.
- dispatch_rs1_value / dispatch_rs2_value  in  32 each  operand value when ready.
- dispatch_tag_to_output  in  6  destination physical tag.
- dispatch_rob_index  in  6  ROB slot.
- wakeup_active  in  1  FU register-result broadcast valid.
- wakeup_tag  in  6  broadcast tag.
- wakeup_value  in  32  broadcast value.
- fu_is_available  in  1  FU accepts a request on this edge.
- fu_write_enable  out  1  issue request to the FU.
- fu_ALUControl, fu_ALUSrc, fu_is_for_lsq, fu_imm, fu_rs1_value, fu_rs2_value, fu_tag_to_output, fu_rob_index  out  4/1/1/32/32/32/6/6  issued instruction fields.
- queue_full  out  1  count == ENTRIES.
- count  out  $clog2(ENTRIES+1)  occupied entries.

## Operation

- Entries are stored in age order. Slot 0 is the oldest. Per entry: valid, payload, rdyN, tagN, valN for N = 1, 2.
- Dispatch is accepted when dispatch_valid && !queue_full && !flush.
  - The new entry is written after all older surviving entries.
  - queue_full is evaluated on the pre-edge count. A dispatch while full is dropped, even if an issue occurs on the same edge.
- rs2 is treated as ready whenever ALUSrc=1, regardless of dispatch_rs2_ready.
- Wakeup applies when wakeup_active && wakeup_tag != 0. Tag 0 never wakes anything.
  - Every valid, not-ready operand whose tag matches sets rdy=1 and val=wakeup_value.
- Dispatch-time snoop: if a dispatched operand is not ready and its tag matches a same-cycle valid wakeup, it is stored ready with wakeup_value.
- Select: the lowest-index valid entry with both operands ready.
- fu_write_enable = fu_is_available && a selected entry exists.
  - While it is 1, the fu_* outputs carry that entry's fields.
  - Otherwise all fu_* outputs are 0.
- On an edge with fu_write_enable=1, the selected entry is removed and younger entries compact down by one. Issue, wakeup and dispatch may all occur on the same edge.
- There is no LSQ-port input. The queue snoops register wakeups only.

## Timing

- Reset and flush: all entries invalid, count=0, queue_full=0, fu_write_enable=0, all fu_* = 0. Both take effect on the edge and override dispatch, issue and wakeup.
- fu_write_enable and fu_* are combinational from queue state and fu_is_available only. There is no combinational path from dispatch_* or wakeup_* to fu_*.
- Dispatch-to-issue latency:
  - Operands ready at dispatch: earliest issue is the cycle after the dispatch edge.
  - Woken operand: earliest issue is the cycle after the wakeup edge.
- Issue handshake: the FU samples fu_* on the same rising edge the queue removes the entry. Exactly one instruction per edge.
- If fu_is_available is low, nothing is removed and entries hold indefinitely.
- count and queue_full update on the edge:
  - count' = count + accepted_dispatch − issued.
  - queue_full drops the cycle after an issue from a full queue.

## Test plan

- Reset, fu_is_available=1. Dispatch ADD (0010), ALUSrc=0, rs1=2 and rs2=3 both ready, tag 4, rob 3 → next cycle fu_write_enable=1, fu_rs1_value=2, fu_rs2_value=3, fu_tag_to_output=4, fu_rob_index=3. After that edge, count=0 and fu_write_enable=0.
- Dispatch SRA (1011), ALUSrc=1, imm=1, rs1 not ready with tag 7 → no issue. Next cycle wakeup tag 7 value 0xFFFFFFFB → issue the following cycle with fu_rs1_value=0xFFFFFFFB, fu_ALUSrc=1, fu_imm=1. A prior wakeup with tag 0 causes no wakeup.
- Dispatch A (rs1 waiting on tag 9), then B and C (ready) → B then C issue on consecutive edges. Wakeup tag 9 → A issues next; A is the oldest once ready.
- Hold fu_is_available=0 with 3 ready entries → fu_write_enable=0 and count stays 3. Raise fu_is_available → one issue per cycle, oldest first.
- ENTRIES=8: dispatch 8 entries with rs1 waiting on tag 12 → queue_full=1. A 9th dispatch is dropped (count stays 8). Wakeup tag 12 → issue; one cycle later queue_full=0.
- Dispatch with rs2 tag 5 not ready, concurrent with wakeup tag 5 value 42 → entry ready, issues next cycle with fu_rs2_value=42. Flush asserted with 4 entries plus a concurrent dispatch → count=0 and no issue afterwards.
